// File: rtl/ps2_cmd_sequencer.sv
// Host-to-device PS/2 command sequencer: sends a command and an optional argument through
// PS2_Controller, handles ACK/RESEND and timeouts, and optionally captures one response byte.
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT  = 1_000_000,
  parameter int RESP_TIMEOUT = 50_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       req,
  input  logic [7:0] req_cmd,
  input  logic       req_has_arg,
  input  logic [7:0] req_arg,
  input  logic       req_resp,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] resp_data,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en
);

  localparam int TMAX = (ACK_TIMEOUT > RESP_TIMEOUT) ? ACK_TIMEOUT : RESP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST   = TW'(RESP_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NAK     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_LINE    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_GAP,
    S_WAIT_ACK,
    S_WAIT_RESP,
    S_FIN
  } state_t;

  state_t        state, state_n;
  logic [7:0]    arg_q, arg_n;
  logic          has_arg_q, has_arg_n;
  logic          want_resp_q, want_resp_n;
  logic          arg_phase, arg_phase_n;
  logic [3:0]    retry, retry_n;
  logic [TW-1:0] timer, timer_n;

  logic          busy_n, done_n, key_valid_n, send_command_n;
  logic [1:0]    status_n;
  logic [7:0]    resp_data_n, key_data_n, the_command_n;
  logic          forward;

  // Retries resend the_command as held, so the command byte needs no separate copy.
  always_comb begin
    state_n        = state;
    arg_n          = arg_q;
    has_arg_n      = has_arg_q;
    want_resp_n    = want_resp_q;
    arg_phase_n    = arg_phase;
    retry_n        = retry;
    timer_n        = timer;
    busy_n         = busy;
    done_n         = 1'b0;
    status_n       = ST_OK;
    resp_data_n    = 8'h00;
    the_command_n  = the_command;
    send_command_n = send_command;
    forward        = received_data_en;

    case (state)
      S_IDLE: begin
        if (req) begin
          arg_n          = req_arg;
          has_arg_n      = req_has_arg;
          want_resp_n    = req_resp;
          arg_phase_n    = 1'b0;
          retry_n        = 4'd0;
          the_command_n  = req_cmd;
          send_command_n = 1'b1;
          busy_n         = 1'b1;
          state_n        = S_TX;
        end
      end

      S_TX: begin
        if (error_communication_timed_out) begin
          send_command_n = 1'b0;
          busy_n         = 1'b0;
          done_n         = 1'b1;
          status_n       = ST_LINE;
          state_n        = S_FIN;
        end else if (command_was_sent) begin
          send_command_n = 1'b0;
          state_n        = S_GAP;
        end
      end

      S_GAP: begin
        timer_n = '0;
        state_n = S_WAIT_ACK;
      end

      // A consumed ACK/RESEND takes priority over a timer expiring in the same cycle.
      S_WAIT_ACK: begin
        if (received_data_en && received_data == BYTE_ACK) begin
          forward = 1'b0;
          if (!arg_phase && has_arg_q) begin
            arg_phase_n    = 1'b1;
            the_command_n  = arg_q;
            send_command_n = 1'b1;
            state_n        = S_TX;
          end else if (want_resp_q) begin
            timer_n = '0;
            state_n = S_WAIT_RESP;
          end else begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            status_n = ST_OK;
            state_n = S_FIN;
          end
        end else if (received_data_en && received_data == BYTE_RESEND) begin
          forward = 1'b0;
          if (retry < RETRY_LIMIT) begin
            retry_n        = retry + 4'd1;
            send_command_n = 1'b1;
            state_n        = S_TX;
          end else begin
            busy_n   = 1'b0;
            done_n   = 1'b1;
            status_n = ST_NAK;
            state_n  = S_FIN;
          end
        end else if (timer == ACK_LAST) begin
          busy_n   = 1'b0;
          done_n   = 1'b1;
          status_n = ST_TIMEOUT;
          state_n  = S_FIN;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_WAIT_RESP: begin
        if (received_data_en) begin
          forward     = 1'b0;
          resp_data_n = received_data;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          status_n    = ST_OK;
          state_n     = S_FIN;
        end else if (timer == RESP_LAST) begin
          busy_n   = 1'b0;
          done_n   = 1'b1;
          status_n = ST_TIMEOUT;
          state_n  = S_FIN;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_FIN: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    key_valid_n = forward;
    key_data_n  = forward ? received_data : key_data;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      arg_q        <= 8'h00;
      has_arg_q    <= 1'b0;
      want_resp_q  <= 1'b0;
      arg_phase    <= 1'b0;
      retry        <= 4'd0;
      timer        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= 2'b00;
      resp_data    <= 8'h00;
      key_data     <= 8'h00;
      key_valid    <= 1'b0;
      the_command  <= 8'h00;
      send_command <= 1'b0;
    end else begin
      state        <= state_n;
      arg_q        <= arg_n;
      has_arg_q    <= has_arg_n;
      want_resp_q  <= want_resp_n;
      arg_phase    <= arg_phase_n;
      retry        <= retry_n;
      timer        <= timer_n;
      busy         <= busy_n;
      done         <= done_n;
      status       <= status_n;
      resp_data    <= resp_data_n;
      key_data     <= key_data_n;
      key_valid    <= key_valid_n;
      the_command  <= the_command_n;
      send_command <= send_command_n;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Testbench for ps2_cmd_sequencer: scripted PS/2 device replies checked against a
// transaction-level model of the send/retry/response rules.
module tb_ps2_cmd_sequencer;

  localparam int ACK_TIMEOUT  = 100;
  localparam int RESP_TIMEOUT = 300;
  localparam int MAX_RETRY    = 2;
  localparam int ACK  = 250;
  localparam int RSND = 254;

  logic       CLOCK_50, resetn, req, req_has_arg, req_resp;
  logic [7:0] req_cmd, req_arg;
  logic       busy, done, key_valid, send_command;
  logic [1:0] status;
  logic [7:0] resp_data, key_data, the_command;
  logic       command_was_sent, error_communication_timed_out, received_data_en;
  logic [7:0] received_data;

  ps2_cmd_sequencer #(
    .ACK_TIMEOUT(ACK_TIMEOUT), .RESP_TIMEOUT(RESP_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req), .req_cmd(req_cmd),
    .req_has_arg(req_has_arg), .req_arg(req_arg), .req_resp(req_resp),
    .busy(busy), .done(done), .status(status), .resp_data(resp_data),
    .key_data(key_data), .key_valid(key_valid), .the_command(the_command),
    .send_command(send_command), .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data(received_data), .received_data_en(received_data_en)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int fails  = 0;

  // Device script: per send attempt ACK, RSND, -1 (silent) or -2 (controller error pulse)
  int acks[$];
  int resp_byte;
  int noise_val;

  logic [7:0] exp_sends[$];
  int exp_status, exp_resp;
  bit exp_resp_phase;

  int tick_cnt = 0;
  int done_cnt = 0;
  int done_tick = 0;
  logic [1:0] done_status;
  logic [7:0] done_resp;
  logic done_busy;
  logic [7:0] fwd_q[$];

  always @(negedge CLOCK_50) begin
    tick_cnt = tick_cnt + 1;
    if (key_valid) fwd_q.push_back(key_data);
    if (done) begin
      done_cnt    = done_cnt + 1;
      done_tick   = tick_cnt;
      done_status = status;
      done_resp   = resp_data;
      done_busy   = busy;
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  // Transaction-level reference: walk the device script through the ACK/RESEND rules
  task automatic model_txn(input logic [7:0] cmd, input bit has_arg, input logic [7:0] arg,
                           input bit want_resp);
    logic [7:0] bytes_q[$];
    int idx, tries, k, r;
    exp_sends.delete();
    exp_status = 0; exp_resp = 0; exp_resp_phase = 0;
    bytes_q.delete();
    bytes_q.push_back(cmd);
    if (has_arg) bytes_q.push_back(arg);
    idx = 0; tries = 0; k = 0;
    while (1) begin
      exp_sends.push_back(bytes_q[idx]);
      r = (k < acks.size()) ? acks[k] : -1;
      k++;
      if (r == -2) begin exp_status = 3; break; end
      if (r == RSND) begin
        if (tries < MAX_RETRY) begin tries++; continue; end
        exp_status = 1; break;
      end
      if (r == ACK) begin
        idx++;
        if (idx < bytes_q.size()) continue;
        if (want_resp) begin
          exp_resp_phase = 1;
          if (resp_byte < 0) exp_status = 2;
          else begin exp_status = 0; exp_resp = resp_byte; end
        end else exp_status = 0;
        break;
      end
      exp_status = 2;
      break;
    end
  endtask

  task automatic run_txn(input string name, input logic [7:0] cmd, input bit has_arg,
                         input logic [7:0] arg, input bit want_resp);
    int n, r, base_done, gap_tick, last_tick;
    bit ok;
    logic [7:0] exp_fwd[$];
    model_txn(cmd, has_arg, arg, want_resp);
    base_done = done_cnt; fwd_q.delete(); ok = 1; gap_tick = 0; last_tick = 0;
    req = 1'b1; req_cmd = cmd; req_has_arg = has_arg; req_arg = arg; req_resp = want_resp;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("[TB] FAIL %s accept: busy=%b required 1", name, busy); fails++; ok = 0;
    end
    for (int i = 0; ok && i < exp_sends.size(); i++) begin
      n = 0;
      while (send_command !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (send_command !== 1'b1) begin
        $display("[TB] FAIL %s send[%0d]: send_command=%b required 1", name, i, send_command);
        fails++; ok = 0;
      end else begin
        checks++;
        if (the_command !== exp_sends[i]) begin
          $display("[TB] FAIL %s byte[%0d]: got %02h required %02h", name, i, the_command, exp_sends[i]);
          fails++;
        end
        repeat ($urandom_range(0, 3)) tick();
        r = acks[i];
        if (r == -2) begin
          error_communication_timed_out = 1'b1; tick(); error_communication_timed_out = 1'b0;
          checks++;
          if (send_command !== 1'b0) begin
            $display("[TB] FAIL %s err_drop: send_command=%b required 0", name, send_command); fails++;
          end
        end else begin
          command_was_sent = 1'b1; tick(); command_was_sent = 1'b0;
          checks++;
          if (send_command !== 1'b0) begin
            $display("[TB] FAIL %s gap[%0d]: send_command=%b required 0", name, i, send_command); fails++;
          end
          gap_tick = tick_cnt;
          tick();
          if (r >= 0) begin
            if (noise_val >= 0 && i == 0) begin
              rx_byte(8'(noise_val));
              exp_fwd.push_back(8'(noise_val));
            end
            repeat ($urandom_range(0, 4)) tick();
            last_tick = tick_cnt;
            rx_byte(8'(r));
          end
        end
      end
    end
    if (ok && exp_resp_phase && resp_byte >= 0) begin
      repeat ($urandom_range(0, 4)) tick();
      rx_byte(8'(resp_byte));
    end
    n = 0;
    while (done_cnt == base_done && n < 1000) begin tick(); n++; end
    checks++;
    if (done_cnt == base_done) begin
      $display("[TB] FAIL %s done: no done pulse within 1000 cycles, required one", name);
      fails++; ok = 0;
    end else begin
      checks++;
      if (done_status !== 2'(exp_status)) begin
        $display("[TB] FAIL %s status: got %0d required %0d", name, done_status, exp_status); fails++;
      end
      checks++;
      if (done_resp !== 8'(exp_resp)) begin
        $display("[TB] FAIL %s resp_data: got %02h required %02h", name, done_resp, 8'(exp_resp)); fails++;
      end
      checks++;
      if (done_busy !== 1'b0) begin
        $display("[TB] FAIL %s busy_at_done: got %b required 0", name, done_busy); fails++;
      end
      if (exp_status == 2) begin
        checks++;
        if (exp_resp_phase && done_tick - last_tick != RESP_TIMEOUT + 1) begin
          $display("[TB] FAIL %s resp_timeout_cycles: got %0d required %0d", name,
                   done_tick - last_tick, RESP_TIMEOUT + 1); fails++;
        end else if (!exp_resp_phase && done_tick - gap_tick != ACK_TIMEOUT + 1) begin
          $display("[TB] FAIL %s ack_timeout_cycles: got %0d required %0d", name,
                   done_tick - gap_tick, ACK_TIMEOUT + 1); fails++;
        end
      end
    end
    tick(); tick();
    checks++;
    if (done_cnt != base_done + 1) begin
      $display("[TB] FAIL %s done_count: got %0d required 1", name, done_cnt - base_done); fails++;
    end
    checks++;
    if (fwd_q.size() != exp_fwd.size()) begin
      $display("[TB] FAIL %s fwd_count: got %0d required %0d", name, fwd_q.size(), exp_fwd.size()); fails++;
    end else begin
      foreach (exp_fwd[j]) begin
        checks++;
        if (fwd_q[j] !== exp_fwd[j]) begin
          $display("[TB] FAIL %s fwd[%0d]: got %02h required %02h", name, j, fwd_q[j], exp_fwd[j]); fails++;
        end
      end
    end
    if (!ok) begin
      resetn = 1'b0; tick(); resetn = 1'b1; tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 0; req_cmd = 0; req_has_arg = 0; req_arg = 0; req_resp = 0;
    command_was_sent = 0; error_communication_timed_out = 0; received_data = 0; received_data_en = 0;
    tick(); tick();
    checks++;
    if ({busy, done, status, resp_data, key_data, key_valid, the_command, send_command} !== 30'd0) begin
      $display("[TB] FAIL reset_outputs: got %08h required 0",
               {busy, done, status, resp_data, key_data, key_valid, the_command, send_command});
      fails++;
    end
    resetn = 1'b1; tick();
  endtask

  task automatic test_led_cmd();
    acks = '{ACK, ACK}; resp_byte = -1; noise_val = -1;
    run_txn("led_cmd", 8'hED, 1'b1, 8'h07, 1'b0);
  endtask

  task automatic test_resend();
    acks = '{RSND, RSND, ACK}; resp_byte = -1; noise_val = -1;
    run_txn("resend_ok", 8'hF4, 1'b0, 8'h00, 1'b0);
    acks = '{RSND, RSND, RSND}; noise_val = -1;
    run_txn("resend_nak", 8'hF4, 1'b0, 8'h00, 1'b0);
    acks = '{ACK, RSND, ACK}; noise_val = -1;
    run_txn("resend_arg", 8'hF3, 1'b1, 8'h0A, 1'b0);
  endtask

  task automatic test_bat();
    acks = '{ACK}; resp_byte = 8'hAA; noise_val = -1;
    run_txn("bat", 8'hFF, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    acks = '{-1}; resp_byte = -1; noise_val = -1;
    run_txn("ack_timeout", 8'hF2, 1'b0, 8'h00, 1'b0);
    acks = '{-2}; noise_val = -1;
    run_txn("line_error", 8'hF5, 1'b0, 8'h00, 1'b0);
    acks = '{ACK, -2}; noise_val = -1;
    run_txn("line_error_arg", 8'hED, 1'b1, 8'h02, 1'b0);
    acks = '{ACK}; resp_byte = -1; noise_val = -1;
    run_txn("resp_timeout", 8'hFF, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_passthrough();
    logic [7:0] sent[$];
    logic [7:0] b;
    fwd_q.delete();
    sent = '{8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 3; i++) rx_byte(sent[i]);
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hFA : 8'($urandom);
      sent.push_back(b);
      repeat ($urandom_range(0, 2)) tick();
      rx_byte(b);
    end
    tick(); tick();
    checks++;
    if (fwd_q.size() != sent.size()) begin
      $display("[TB] FAIL idle_fwd_count: got %0d required %0d", fwd_q.size(), sent.size()); fails++;
    end else begin
      foreach (sent[j]) begin
        checks++;
        if (fwd_q[j] !== sent[j]) begin
          $display("[TB] FAIL idle_fwd[%0d]: got %02h required %02h", j, fwd_q[j], sent[j]); fails++;
        end
      end
    end
    acks = '{ACK}; resp_byte = -1; noise_val = 8'h1C;
    run_txn("wait_ack_fwd", 8'hF4, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, base;
    base = done_cnt;
    req = 1'b1; req_cmd = 8'hF4; req_has_arg = 1'b0; req_arg = 8'h00; req_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (send_command !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (send_command !== 1'b1 || the_command !== 8'hF4) begin
        $display("[TB] FAIL b2b_send[%0d]: send=%b byte=%02h required 1/F4", k, send_command, the_command);
        fails++;
      end
      command_was_sent = 1'b1; tick(); command_was_sent = 1'b0;
      tick();
      rx_byte(8'hFA);
      n = 0;
      while (done_cnt == base + k && n < 20) begin tick(); n++; end
      checks++;
      if (done_cnt != base + k + 1 || done_status !== 2'b00) begin
        $display("[TB] FAIL b2b_done[%0d]: count=%0d status=%0d required %0d/0", k,
                 done_cnt - base, done_status, k + 1); fails++;
      end
      if (k == 0) begin
        tick();
        checks++;
        if (busy !== 1'b0) begin
          $display("[TB] FAIL b2b_fin_cycle: busy=%b required 0", busy); fails++;
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
          $display("[TB] FAIL b2b_accept: busy=%b required 1", busy); fails++;
        end
        req = 1'b0;
      end
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n, base;
    req = 1'b1; req_cmd = 8'hF3; req_has_arg = 1'b1; req_arg = 8'h20; req_resp = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    req = 1'b0;
    command_was_sent = 1'b1; tick(); command_was_sent = 1'b0;
    tick(); tick();
    base = done_cnt;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, status, resp_data, key_data, key_valid, the_command, send_command} !== 30'd0) begin
      $display("[TB] FAIL mid_reset_outputs: got %08h required 0",
               {busy, done, status, resp_data, key_data, key_valid, the_command, send_command});
      fails++;
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != base) begin
      $display("[TB] FAIL mid_reset_done: got %0d pulses required 0", done_cnt - base); fails++;
    end
    resetn = 1'b1; tick();
    acks = '{ACK, ACK}; resp_byte = -1; noise_val = -1;
    run_txn("after_reset", 8'hF3, 1'b1, 8'h20, 1'b0);
  endtask

  task automatic test_random();
    int p, nb;
    for (int t = 0; t < 25; t++) begin
      acks.delete();
      for (int j = 0; j < 8; j++) begin
        p = $urandom_range(0, 99);
        acks.push_back(p < 60 ? ACK : p < 85 ? RSND : p < 93 ? -1 : -2);
      end
      resp_byte = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 255));
      nb = $urandom_range(0, 255);
      if (nb == ACK || nb == RSND) nb = 8'h1C;
      noise_val = ($urandom_range(0, 2) == 0) ? nb : -1;
      run_txn("random", 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_resend();
    test_bat();
    test_timeout();
    test_passthrough();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
